// File: rtl/bf_sweep_ctrl.sv
// bf_sweep_ctrl
//   Sweeps every input vector of a small combinational boolean-function block
//   in ascending order. Each vector is held for a programmable settle time,
//   then the block output is sampled into a measured truth table. When the
//   sweep ends, that table is compared against an expected table.
//
// Parameters
//   N_IN        number of function inputs (table width 2**N_IN)
//   SETTLE_CYC  cycles spent in SETTLE before sampling (1..255)
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   start          sweep request, honoured only while idle
//   expected       expected truth table, latched when start is accepted
//   dut_out        output of the function block being swept
//   drv_vec        registered input vector to the block (MSB = inA)
//   busy           high from start acceptance until the done cycle ends
//   done           one-cycle completion pulse
//   truth_tbl      measured table, bit i = output with drv_vec == i
//   match          truth_tbl equals the latched expected table
//   fail_valid     first mismatch has been captured
//   first_fail_idx vector index of the first mismatch
//
// Configuration
//   BF_SWEEP_FIRST_FAIL_EN  when defined, builds first-mismatch capture;
//                           otherwise fail_valid/first_fail_idx read as 0.

module bf_sweep_ctrl #(
  parameter int N_IN       = 3,
  parameter int SETTLE_CYC = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [(2**N_IN)-1:0]   expected,
  input  logic                   dut_out,
  output logic [N_IN-1:0]        drv_vec,
  output logic                   busy,
  output logic                   done,
  output logic [(2**N_IN)-1:0]   truth_tbl,
  output logic                   match,
  output logic                   fail_valid,
  output logic [N_IN-1:0]        first_fail_idx
);

  localparam int TBL_W = 2**N_IN;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DRIVE  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [N_IN-1:0] LAST_IDX    = {N_IN{1'b1}};
  // The counter is loaded with SETTLE_CYC-1 and SETTLE is left when it reads
  // zero, which gives exactly SETTLE_CYC cycles in SETTLE.
  localparam logic [7:0]      SETTLE_LOAD = 8'(SETTLE_CYC - 1);

  logic [2:0]       state_q, state_d;
  logic [N_IN-1:0]  idx_q, idx_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [N_IN-1:0]  drv_q, drv_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [TBL_W-1:0] tbl_q, tbl_d;
  logic [TBL_W-1:0] exp_q, exp_d;
  logic             match_q, match_d;

`ifdef BF_SWEEP_FIRST_FAIL_EN
  logic             fv_q, fv_d;
  logic [N_IN-1:0]  ffi_q, ffi_d;
`endif

  // Next-state and datapath update for the sweep sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    drv_d   = drv_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tbl_d   = tbl_q;
    exp_d   = exp_q;
    match_d = match_q;
`ifdef BF_SWEEP_FIRST_FAIL_EN
    fv_d    = fv_q;
    ffi_d   = ffi_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          exp_d   = expected;
          tbl_d   = '0;
          match_d = 1'b0;
          idx_d   = '0;
          busy_d  = 1'b1;
`ifdef BF_SWEEP_FIRST_FAIL_EN
          fv_d    = 1'b0;
          ffi_d   = '0;
`endif
          state_d = S_DRIVE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRIVE: begin
        drv_d   = idx_q;
        cnt_d   = SETTLE_LOAD;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == 8'd0) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d   = cnt_q - 8'd1;
        end
      end
      S_SAMPLE: begin
        tbl_d[idx_q] = dut_out;
`ifdef BF_SWEEP_FIRST_FAIL_EN
        // Only the earliest mismatching vector is kept.
        if ((dut_out != exp_q[idx_q]) && !fv_q) begin
          fv_d  = 1'b1;
          ffi_d = idx_q;
        end else begin
          fv_d  = fv_q;
        end
`endif
        if (idx_q == LAST_IDX) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + {{(N_IN-1){1'b0}}, 1'b1};
          state_d = S_DRIVE;
        end
      end
      S_DONE: begin
        match_d = (tbl_q == exp_q);
        drv_d   = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= 8'd0;
      drv_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tbl_q   <= '0;
      exp_q   <= '0;
      match_q <= 1'b0;
`ifdef BF_SWEEP_FIRST_FAIL_EN
      fv_q    <= 1'b0;
      ffi_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      drv_q   <= drv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tbl_q   <= tbl_d;
      exp_q   <= exp_d;
      match_q <= match_d;
`ifdef BF_SWEEP_FIRST_FAIL_EN
      fv_q    <= fv_d;
      ffi_q   <= ffi_d;
`endif
    end
  end

  assign drv_vec   = drv_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign truth_tbl = tbl_q;
  assign match     = match_q;

`ifdef BF_SWEEP_FIRST_FAIL_EN
  assign fail_valid     = fv_q;
  assign first_fail_idx = ffi_q;
`else
  assign fail_valid     = 1'b0;
  assign first_fail_idx = '0;
`endif

endmodule

// File: tb/tb_bf_sweep_ctrl.sv
// Self-checking bench for bf_sweep_ctrl. Instance A uses the default settle
// time (6 cycles per vector) and instance B uses SETTLE_CYC=1 (3 cycles per
// vector). The reference model predicts every cycle of a sweep from the
// acceptance edge using plain arithmetic on the cycle number.

module tb_bf_sweep_ctrl;

  localparam int P_A = 6;
  localparam int P_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_a, start_b, dut_a, dut_b;
  logic [7:0] exp_a, exp_b;
  logic [2:0] drv_a, drv_b, ffi_a, ffi_b;
  logic       busy_a, busy_b, done_a, done_b, match_a, match_b, fv_a, fv_b;
  logic [7:0] tbl_a, tbl_b;

  bf_sweep_ctrl u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .expected(exp_a), .dut_out(dut_a),
    .drv_vec(drv_a), .busy(busy_a), .done(done_a), .truth_tbl(tbl_a),
    .match(match_a), .fail_valid(fv_a), .first_fail_idx(ffi_a)
  );

  bf_sweep_ctrl #(.N_IN(3), .SETTLE_CYC(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .expected(exp_b), .dut_out(dut_b),
    .drv_vec(drv_b), .busy(busy_b), .done(done_b), .truth_tbl(tbl_b),
    .match(match_b), .fail_valid(fv_b), .first_fail_idx(ffi_b)
  );

  int checks   = 0;
  int failures = 0;

  logic       sel;
  logic [2:0] drv_s, ffi_s;
  logic       busy_s, done_s, match_s, fv_s;
  logic [7:0] tbl_s;

  always_comb begin
    drv_s   = sel ? drv_b   : drv_a;
    ffi_s   = sel ? ffi_b   : ffi_a;
    busy_s  = sel ? busy_b  : busy_a;
    done_s  = sel ? done_b  : done_a;
    match_s = sel ? match_b : match_a;
    fv_s    = sel ? fv_b    : fv_a;
    tbl_s   = sel ? tbl_b   : tbl_a;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    if (obs !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, req, $time);
    end
  endtask

  task automatic set_in(input logic st, input logic [7:0] ex, input logic d);
    if (sel) begin
      start_b = st; exp_b = ex; dut_b = d;
    end else begin
      start_a = st; exp_a = ex; dut_a = d;
    end
  endtask

  function automatic int first_diff(input logic [7:0] a, input logic [7:0] b);
    for (int i = 0; i < 8; i++) if (a[i] != b[i]) return i;
    return 0;
  endfunction

  // One sweep on the selected instance. f is the function's truth table.
  // restart_at: cycle at which a stray start is pulsed (-1 = none).
  // abort_at:   cycle at which rst_n is pulled low (-1 = none).
  task automatic sweep(input logic [7:0] f, input logic [7:0] ex,
                       input int restart_at, input int abort_at);
    int         p;
    int         total;
    int         vec_m;
    logic [7:0] tbl_m;
    logic       d;
    logic       st;
    logic       fv_m;
    int         ffi_m;
    p     = sel ? P_B : P_A;
    total = 8 * p;
`ifdef BF_SWEEP_FIRST_FAIL_EN
    fv_m  = (f != ex);
    ffi_m = (f != ex) ? first_diff(f, ex) : 0;
`else
    fv_m  = 1'b0;
    ffi_m = 0;
`endif
    set_in(1'b1, ex, 1'($urandom_range(0, 1)));
    @(negedge clk);
    // n counts cycles after the accepting edge.
    for (int n = 0; n <= total + 1; n++) begin
      if (n == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_val("abort_drv",  32'(drv_s),  32'd0);
        check_val("abort_busy", 32'(busy_s), 32'd0);
        check_val("abort_tbl",  32'(tbl_s),  32'd0);
        check_val("abort_done", 32'(done_s), 32'd0);
        set_in(1'b0, ex, 1'b0);
        repeat (3) begin
          @(negedge clk);
          check_val("abort_hold_done", 32'(done_s), 32'd0);
          check_val("abort_hold_busy", 32'(busy_s), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        return;
      end
      vec_m = (n == 0 || n > total) ? 0 : (n - 1) / p;
      tbl_m = 8'h00;
      for (int k = 0; k < 8; k++) if ((k + 1) * p <= n) tbl_m[k] = f[k];
      check_val("drv_vec", 32'(drv_s),  32'(vec_m));
      check_val("busy",    32'(busy_s), 32'(n <= total));
      check_val("done",    32'(done_s), 32'(n == total));
      check_val("tbl",     32'(tbl_s),  32'(tbl_m));
      if (n < total) check_val("match_clr", 32'(match_s), 32'd0);
      if (n == total + 1) begin
        check_val("match",          32'(match_s), 32'(f == ex));
        check_val("fail_valid",     32'(fv_s),    32'(fv_m));
        check_val("first_fail_idx", 32'(ffi_s),   32'(ffi_m));
      end
      // Drive the true function value only into the edge that samples;
      // any other cycle gets a random glitch value.
      if (((n + 1) % p == 0) && (n + 1 <= total)) d = f[vec_m];
      else d = 1'($urandom_range(0, 1));
      // A start in the DONE cycle must be ignored as well.
      st = (n == restart_at) || (n == total);
      set_in(st, 8'($urandom), d);
      @(negedge clk);
    end
    repeat (4) begin
      check_val("idle_busy", 32'(busy_s), 32'd0);
      check_val("idle_done", 32'(done_s), 32'd0);
      check_val("idle_tbl",  32'(tbl_s),  32'(f));
      check_val("idle_match", 32'(match_s), 32'(f == ex));
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] rf, re;
    sel = 1'b0;
    rst_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; dut_a = 1'b0; dut_b = 1'b0;
    exp_a = 8'h00; exp_b = 8'h00;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      check_val("rst_drv",   32'(drv_s),   32'd0);
      check_val("rst_busy",  32'(busy_s),  32'd0);
      check_val("rst_done",  32'(done_s),  32'd0);
      check_val("rst_tbl",   32'(tbl_s),   32'd0);
      check_val("rst_match", 32'(match_s), 32'd0);
      check_val("rst_fv",    32'(fv_s),    32'd0);
      check_val("rst_ffi",   32'(ffi_s),   32'd0);
    end
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    sweep(8'hEA, 8'hEA, -1, -1);
    sweep(8'hEA, 8'hEB, -1, -1);
    sweep(8'h00, 8'h00, -1, -1);
    sweep(8'hFF, 8'h7F, -1, -1);
    sweep(8'hEA, 8'hEA, 10, -1);
    sweep(8'hEA, 8'hEA, -1, 20);
    sweep(8'hEA, 8'hEA, -1, -1);
    for (int r = 0; r < 4; r++) begin
      rf = 8'($urandom);
      re = ($urandom_range(0, 1) == 1) ? rf : 8'($urandom);
      sweep(rf, re, -1, -1);
    end

    sel = 1'b1;
    #1;
    sweep(8'hEA, 8'hEA, -1, -1);
    for (int r = 0; r < 2; r++) begin
      rf = 8'($urandom);
      re = 8'($urandom);
      sweep(rf, re, -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
